// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the seven-segment display driver.
//   - active-low segment patterns, bit order {g,f,e,d,c,b,a}
//   - conversion FSM state encoding
//   - pow10_m1(n): largest value displayable on n decimal digits
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // 10^n - 1; only evaluated at elaboration time for the overflow limit
   function automatic int unsigned pow10_m1(input int unsigned n);
      int unsigned p;
      p = 1;
      for (int unsigned i = 0; i < n; i++) p = p * 10;
      return p - 1;
   endfunction

endpackage

// File: rtl/seg7_digit_enc.sv
// seg7_digit_enc: one BCD digit to an active-low seven-segment pattern.
//   bcd   in  4  BCD digit; codes 10-15 are shown blank
//   blank in  1  force the digit dark (leading-zero blanking)
//   seg   out 7  pattern {g,f,e,d,c,b,a}, active low
module seg7_digit_enc
   import seg7_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (!blank) begin
         case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/seg7_bin_display.sv
// seg7_bin_display: binary value -> NDIGITS active-low seven-segment digits.
// A load captures value, a shift-add-3 engine converts one bit per cycle, and
// the patterns are registered WIDTH+1 cycles after the load edge.
//   clk   in  1          system clock
//   rst_n in  1          synchronous active-low reset
//   value in  WIDTH      unsigned value to display
//   load  in  1          start conversion (ignored while busy)
//   busy  out 1          conversion in progress
//   valid out 1          one-cycle pulse when seg/ovf are updated
//   ovf   out 1          value did not fit in NDIGITS digits (all dashes)
//   seg   out 7*NDIGITS  digit i (units = 0) at seg[7*i+6:7*i]
module seg7_bin_display
   import seg7_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int NDIGITS  = 3,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [WIDTH-1:0]       value,
   input  logic                   load,
   output logic                   busy,
   output logic                   valid,
   output logic                   ovf,
   output logic [7*NDIGITS-1:0]   seg
);

   localparam int          CNT_W    = $clog2(WIDTH + 1);
   localparam int          BCD_W    = 4 * NDIGITS;
   localparam int unsigned MAX_DISP = pow10_m1(NDIGITS);

   // Idle display: a single "0" on the units digit, the rest blank or "0"
   function automatic logic [7*NDIGITS-1:0] rst_pattern();
      logic [7*NDIGITS-1:0] p;
      for (int i = 0; i < NDIGITS; i++)
         p[7*i +: 7] = (i == 0 || !BLANK_LZ) ? SEG_0 : SEG_BLANK;
      return p;
   endfunction

   localparam logic [7*NDIGITS-1:0] SEG_RST = rst_pattern();

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]     bin_q, bin_d;
   logic [BCD_W-1:0]     bcd_q, bcd_d;
   logic                 ovf_pend_q, ovf_pend_d;
   logic                 busy_q, busy_d;
   logic                 valid_q, valid_d;
   logic                 ovf_q, ovf_d;
   logic [7*NDIGITS-1:0] seg_q, seg_d;

   logic [BCD_W-1:0]     bcd_adj;
   logic [NDIGITS:0]     lz;       // lz[i]: digits i and above are all zero
   logic [7*NDIGITS-1:0] enc_seg;

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         bin_q      <= '0;
         bcd_q      <= '0;
         ovf_pend_q <= 1'b0;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
         ovf_q      <= 1'b0;
         seg_q      <= SEG_RST;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bin_q      <= bin_d;
         bcd_q      <= bcd_d;
         ovf_pend_q <= ovf_pend_d;
         busy_q     <= busy_d;
         valid_q    <= valid_d;
         ovf_q      <= ovf_d;
         seg_q      <= seg_d;
      end
   end

   // ---------------- next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (load) state_d = ST_SHIFT;
         ST_SHIFT: if (cnt_q == '0) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // ---------------- datapath / outputs ----------------
   // Add 3 to every nibble >= 5 before the shift so it carries correctly
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < NDIGITS; i++)
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
   end

   always_comb begin
      lz          = '0;
      lz[NDIGITS] = 1'b1;
      for (int i = NDIGITS - 1; i >= 0; i--)
         lz[i] = lz[i+1] & (bcd_q[4*i +: 4] == 4'd0);
   end

   for (genvar g = 0; g < NDIGITS; g++) begin : g_dig
      logic blank_g;
      assign blank_g = BLANK_LZ && (g != 0) && lz[g];
      seg7_digit_enc u_enc (
         .bcd   (bcd_q[4*g +: 4]),
         .blank (blank_g),
         .seg   (enc_seg[7*g +: 7])
      );
   end

   always_comb begin
      cnt_d      = cnt_q;
      bin_d      = bin_q;
      bcd_d      = bcd_q;
      ovf_pend_d = ovf_pend_q;
      ovf_d      = ovf_q;
      seg_d      = seg_q;
      valid_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (load) begin
               bin_d      = value;
               bcd_d      = '0;
               cnt_d      = CNT_W'(WIDTH - 1);
               // folds to 0 when every WIDTH-bit value fits in NDIGITS
               ovf_pend_d = (32'(value) > MAX_DISP);
            end
         end
         ST_SHIFT: begin
            {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
            cnt_d          = cnt_q - 1'b1;
         end
         ST_DONE: begin
            ovf_d   = ovf_pend_q;
            valid_d = 1'b1;
            seg_d   = ovf_pend_q ? {NDIGITS{SEG_DASH}} : enc_seg;
         end
         default: ;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   assign busy  = busy_q;
   assign valid = valid_q;
   assign ovf   = ovf_q;
   assign seg   = seg_q;

endmodule

// File: tb/tb_seg7_bin_display.sv
module tb_seg7_bin_display;

   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                          S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                          S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                          S9 = 7'b0010000, SB = 7'b1111111, SD = 7'b0111111;

   logic clk, rst_n;
   logic load0, load1, load2, load3;
   logic [7:0]  value0, value1, value2;
   logic [13:0] value3;
   logic busy0, busy1, busy2, busy3;
   logic valid0, valid1, valid2, valid3;
   logic ovf0, ovf1, ovf2, ovf3;
   logic [20:0] seg0, seg1;
   logic [13:0] seg2;
   logic [27:0] seg3;

   int total = 0;
   int bad   = 0;

   // d0: 8b/3dig/blank  d1: 8b/3dig/no blank  d2: 8b/2dig/blank  d3: 14b/4dig/blank
   seg7_bin_display #(.WIDTH(8),  .NDIGITS(3), .BLANK_LZ(1'b1)) u0 (
      .clk(clk), .rst_n(rst_n), .value(value0), .load(load0),
      .busy(busy0), .valid(valid0), .ovf(ovf0), .seg(seg0));
   seg7_bin_display #(.WIDTH(8),  .NDIGITS(3), .BLANK_LZ(1'b0)) u1 (
      .clk(clk), .rst_n(rst_n), .value(value1), .load(load1),
      .busy(busy1), .valid(valid1), .ovf(ovf1), .seg(seg1));
   seg7_bin_display #(.WIDTH(8),  .NDIGITS(2), .BLANK_LZ(1'b1)) u2 (
      .clk(clk), .rst_n(rst_n), .value(value2), .load(load2),
      .busy(busy2), .valid(valid2), .ovf(ovf2), .seg(seg2));
   seg7_bin_display #(.WIDTH(14), .NDIGITS(4), .BLANK_LZ(1'b1)) u3 (
      .clk(clk), .rst_n(rst_n), .value(value3), .load(load3),
      .busy(busy3), .valid(valid3), .ovf(ovf3), .seg(seg3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got no summary in time, required finish");
      $fatal(1);
   end

   typedef struct {
      int          d;
      int          v;
      logic [27:0] seg;
      logic        ovf;
   } vec_t;
   vec_t tbl [12];

   // ---------------- reference model ----------------
   function automatic logic [27:0] ref_seg(input int v, input int nd, input bit blz);
      logic [6:0]  pat [10];
      logic [27:0] r;
      int p, lim;
      pat = '{S0, S1, S2, S3, S4, S5, S6, S7, S8, S9};
      lim = 1;
      for (int i = 0; i < nd; i++) lim = lim * 10;
      lim = lim - 1;
      r = '0;
      p = 1;
      for (int i = 0; i < nd; i++) begin
         if (v > lim)                    r[7*i +: 7] = SD;
         else if (blz && i > 0 && v < p) r[7*i +: 7] = SB;
         else                            r[7*i +: 7] = pat[(v / p) % 10];
         p = p * 10;
      end
      return r;
   endfunction

   // ---------------- DUT access helpers ----------------
   function automatic int width_of(input int d);
      return (d == 3) ? 14 : 8;
   endfunction

   function automatic logic get_busy(input int d);
      case (d) 0: return busy0; 1: return busy1; 2: return busy2; default: return busy3; endcase
   endfunction

   function automatic logic get_valid(input int d);
      case (d) 0: return valid0; 1: return valid1; 2: return valid2; default: return valid3; endcase
   endfunction

   function automatic logic get_ovf(input int d);
      case (d) 0: return ovf0; 1: return ovf1; 2: return ovf2; default: return ovf3; endcase
   endfunction

   function automatic logic [27:0] get_seg(input int d);
      case (d)
         0:       return {7'h0, seg0};
         1:       return {7'h0, seg1};
         2:       return {14'h0, seg2};
         default: return seg3;
      endcase
   endfunction

   task automatic set_load(input int d, input int v, input logic l);
      case (d)
         0: begin load0 = l; if (l) value0 = v[7:0];  end
         1: begin load1 = l; if (l) value1 = v[7:0];  end
         2: begin load2 = l; if (l) value2 = v[7:0];  end
         default: begin load3 = l; if (l) value3 = v[13:0]; end
      endcase
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Called at a negedge; loads v and returns at the negedge of the valid cycle.
   task automatic run_conv(input int d, input int v, input string nm,
                           output logic [27:0] s, output logic o);
      int n, busy_n;
      set_load(d, v, 1'b1);
      @(negedge clk);
      set_load(d, v, 1'b0);
      n = 0;
      busy_n = 0;
      while (!get_valid(d) && n < 64) begin
         if (get_busy(d)) busy_n++;
         @(negedge clk);
         n++;
      end
      chk({nm, " latency"}, n, width_of(d) + 1);
      chk({nm, " busy cycles"}, busy_n, width_of(d) + 1);
      chk({nm, " busy at valid"}, 32'(get_busy(d)), 32'd0);
      s = get_seg(d);
      o = get_ovf(d);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [27:0] s, cap;
      logic        o;
      int          pulses;
      int          v;
      int          corners [6];

      tbl[0]  = '{0, 255, {7'h0, S2, S5, S5}, 1'b0};
      tbl[1]  = '{0, 7,   {7'h0, SB, SB, S7}, 1'b0};
      tbl[2]  = '{1, 7,   {7'h0, S0, S0, S7}, 1'b0};
      tbl[3]  = '{0, 105, {7'h0, S1, S0, S5}, 1'b0};
      tbl[4]  = '{2, 100, {14'h0, SD, SD},    1'b1};
      tbl[5]  = '{2, 99,  {14'h0, S9, S9},    1'b0};
      tbl[6]  = '{0, 0,   {7'h0, SB, SB, S0}, 1'b0};
      tbl[7]  = '{1, 0,   {7'h0, S0, S0, S0}, 1'b0};
      tbl[8]  = '{0, 10,  {7'h0, SB, S1, S0}, 1'b0};
      tbl[9]  = '{2, 5,   {14'h0, SB, S5},    1'b0};
      tbl[10] = '{2, 255, {14'h0, SD, SD},    1'b1};
      tbl[11] = '{1, 42,  {7'h0, S0, S4, S2}, 1'b0};
      corners = '{0, 9, 9999, 10000, 16383, 1000};

      rst_n = 1'b0;
      load0 = 1'b0; load1 = 1'b0; load2 = 1'b0; load3 = 1'b0;
      value0 = '0; value1 = '0; value2 = '0; value3 = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      chk("reset seg d0", 32'(seg0), 32'({SB, SB, S0}));
      chk("reset seg d1", 32'(seg1), 32'({S0, S0, S0}));
      chk("reset seg d2", 32'(seg2), 32'({SB, S0}));
      chk("reset seg d3", 32'(seg3), 32'({SB, SB, SB, S0}));
      chk("reset busy", 32'({busy0, busy1, busy2, busy3}), 32'd0);
      chk("reset valid", 32'({valid0, valid1, valid2, valid3}), 32'd0);
      chk("reset ovf", 32'({ovf0, ovf1, ovf2, ovf3}), 32'd0);

      // table-driven vectors
      for (int i = 0; i < 12; i++) begin
         run_conv(tbl[i].d, tbl[i].v, $sformatf("vec%0d", i), s, o);
         chk($sformatf("vec%0d seg", i), 32'(s), 32'(tbl[i].seg));
         chk($sformatf("vec%0d ovf", i), 32'(o), 32'(tbl[i].ovf));
         @(negedge clk);
         chk($sformatf("vec%0d valid width", i), 32'(get_valid(tbl[i].d)), 32'd0);
      end

      // load while busy is dropped; value change mid-conversion ignored
      set_load(0, 42, 1'b1);
      @(negedge clk);
      set_load(0, 42, 1'b0);
      repeat (3) @(negedge clk);
      set_load(0, 200, 1'b1);
      @(negedge clk);
      set_load(0, 200, 1'b0);
      pulses = 0;
      cap = '0;
      for (int c = 0; c < 30; c++) begin
         if (valid0) begin pulses++; cap = {7'h0, seg0}; end
         @(negedge clk);
      end
      chk("drop pulses", 32'(pulses), 32'd1);
      chk("drop seg", 32'(cap), 32'({SB, S4, S2}));

      // back-to-back: load accepted in the valid cycle
      run_conv(0, 12, "b2b first", s, o);
      chk("b2b first seg", 32'(s), 32'({SB, S1, S2}));
      run_conv(0, 34, "b2b second", s, o);
      chk("b2b second seg", 32'(s), 32'({SB, S3, S4}));
      @(negedge clk);

      // reset mid-SHIFT aborts; d2 still holds ovf=1 from the table
      chk("ovf held before reset", 32'(ovf2), 32'd1);
      set_load(0, 99, 1'b1);
      @(negedge clk);
      set_load(0, 99, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort busy", 32'(busy0), 32'd0);
      chk("abort valid", 32'(valid0), 32'd0);
      chk("abort seg d0", 32'(seg0), 32'({SB, SB, S0}));
      chk("abort ovf d2", 32'(ovf2), 32'd0);
      chk("abort seg d2", 32'(seg2), 32'({SB, S0}));
      rst_n = 1'b1;
      pulses = 0;
      for (int c = 0; c < 20; c++) begin
         if (valid0) pulses++;
         @(negedge clk);
      end
      chk("abort no valid", 32'(pulses), 32'd0);
      run_conv(0, 0, "after abort", s, o);
      chk("after abort digit0", 32'(s[6:0]), 32'(S0));
      chk("after abort seg", 32'(s), 32'({SB, SB, S0}));
      @(negedge clk);

      // randomized against the reference model (d3), loads back-to-back
      for (int i = 0; i < 1006; i++) begin
         v = (i < 6) ? corners[i] : int'($urandom_range(0, 16383));
         run_conv(3, v, $sformatf("rnd v=%0d", v), s, o);
         chk($sformatf("rnd seg v=%0d", v), 32'(s), 32'(ref_seg(v, 4, 1'b1)));
         chk($sformatf("rnd ovf v=%0d", v), 32'(o), 32'(v > 9999));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
